// File: rtl/scratchpad_copy_master.sv
// scratchpad_copy_master
// Copies a block of words from one region of a single-port scratchpad to
// another, one word at a time: READ -> (WAIT) -> CAPTURE -> WRITE. Words are
// copied in ascending order, so each read observes every write issued
// before it. This makes overlapping source/destination regions behave as a
// forward word-by-word copy. Both pointers wrap modulo 2^ADDR_WIDTH.
//
// The port-side outputs come from registers that are loaded with values
// decoded from the *next* state. They therefore line up with the state the
// FSM is in. The only combinational path is the abort gate on chipselect and
// write: abort must be able to cancel the access in the same cycle.

module scratchpad_copy_master #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [ADDR_WIDTH:0]     length,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     words_done,
    output logic [DATA_WIDTH-1:0]   checksum,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    chipselect,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    clken,
    input  logic [DATA_WIDTH-1:0]   readdata
);

    localparam int LEN_WIDTH = ADDR_WIDTH + 1;
    localparam int BE_WIDTH  = DATA_WIDTH / 8;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [BE_WIDTH-1:0]   BE_ZERO   = {BE_WIDTH{1'b0}};
    localparam logic [BE_WIDTH-1:0]   BE_ALL    = {BE_WIDTH{1'b1}};

    // WAIT lasts READ_LATENCY-1 cycles. The counter is loaded with the
    // number of WAIT cycles still to go after the first one.
    localparam logic [1:0] WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                 state_r,      state_s;
    logic [ADDR_WIDTH-1:0]  src_ptr_r,    src_ptr_s;
    logic [ADDR_WIDTH-1:0]  dst_ptr_r,    dst_ptr_s;
    logic [LEN_WIDTH-1:0]   remaining_r,  remaining_s;
    logic [LEN_WIDTH-1:0]   words_done_r, words_done_s;
    logic [DATA_WIDTH-1:0]  checksum_r,   checksum_s;
    logic [DATA_WIDTH-1:0]  data_buf_r,   data_buf_s;
    logic [1:0]             wait_cnt_r,   wait_cnt_s;

    logic                   busy_r,       busy_s;
    logic                   done_r,       done_s;
    logic                   cs_r,         cs_s;
    logic                   wr_r,         wr_s;
    logic [ADDR_WIDTH-1:0]  address_r,    address_s;
    logic [DATA_WIDTH-1:0]  writedata_r,  writedata_s;
    logic [BE_WIDTH-1:0]    byteenable_r, byteenable_s;

    // Next-state and datapath decode for the copy sequencer
    always_comb begin
        state_s      = state_r;
        src_ptr_s    = src_ptr_r;
        dst_ptr_s    = dst_ptr_r;
        remaining_s  = remaining_r;
        words_done_s = words_done_r;
        checksum_s   = checksum_r;
        data_buf_s   = data_buf_r;
        wait_cnt_s   = wait_cnt_r;

        case (state_r)
            ST_IDLE: begin
                // start has priority over abort while idle
                if (start) begin
                    words_done_s = LEN_ZERO;
                    checksum_s   = DATA_ZERO;
                    if (length != LEN_ZERO) begin
                        src_ptr_s   = src_addr;
                        dst_ptr_s   = dst_addr;
                        remaining_s = length;
                        state_s     = ST_READ;
                    end else begin
                        state_s     = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (READ_LATENCY == 1) begin
                    state_s = ST_CAPTURE;
                end else begin
                    wait_cnt_s = WAIT_INIT;
                    state_s    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (wait_cnt_r == 2'd0) begin
                    state_s = ST_CAPTURE;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    data_buf_s = readdata;
                    checksum_s = checksum_r + readdata;
                    state_s    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    src_ptr_s    = src_ptr_r + ADDR_ONE;
                    dst_ptr_s    = dst_ptr_r + ADDR_ONE;
                    remaining_s  = remaining_r - LEN_ONE;
                    words_done_s = words_done_r + LEN_ONE;
                    if (remaining_r == LEN_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        busy_s       = 1'b0;
        done_s       = 1'b0;
        cs_s         = 1'b0;
        wr_s         = 1'b0;
        address_s    = ADDR_ZERO;
        writedata_s  = DATA_ZERO;
        byteenable_s = BE_ZERO;

        case (state_s)
            ST_READ: begin
                busy_s       = 1'b1;
                cs_s         = 1'b1;
                address_s    = src_ptr_s;
                byteenable_s = BE_ALL;
            end
            ST_WAIT: begin
                busy_s = 1'b1;
            end
            ST_CAPTURE: begin
                busy_s = 1'b1;
            end
            ST_WRITE: begin
                busy_s       = 1'b1;
                cs_s         = 1'b1;
                wr_s         = 1'b1;
                address_s    = dst_ptr_s;
                writedata_s  = data_buf_s;
                byteenable_s = BE_ALL;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            src_ptr_r    <= ADDR_ZERO;
            dst_ptr_r    <= ADDR_ZERO;
            remaining_r  <= LEN_ZERO;
            words_done_r <= LEN_ZERO;
            checksum_r   <= DATA_ZERO;
            data_buf_r   <= DATA_ZERO;
            wait_cnt_r   <= 2'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            cs_r         <= 1'b0;
            wr_r         <= 1'b0;
            address_r    <= ADDR_ZERO;
            writedata_r  <= DATA_ZERO;
            byteenable_r <= BE_ZERO;
        end else begin
            state_r      <= state_s;
            src_ptr_r    <= src_ptr_s;
            dst_ptr_r    <= dst_ptr_s;
            remaining_r  <= remaining_s;
            words_done_r <= words_done_s;
            checksum_r   <= checksum_s;
            data_buf_r   <= data_buf_s;
            wait_cnt_r   <= wait_cnt_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            cs_r         <= cs_s;
            wr_r         <= wr_s;
            address_r    <= address_s;
            writedata_r  <= writedata_s;
            byteenable_r <= byteenable_s;
        end
    end

    // abort cancels the access in the cycle it is raised. cs_r is only ever
    // set in busy states, so abort has no effect while idle or done.
    assign chipselect = cs_r & ~abort;
    assign write      = wr_r & ~abort;
    assign address    = address_r;
    assign writedata  = writedata_r;
    assign byteenable = byteenable_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign words_done = words_done_r;
    assign checksum   = checksum_r;
    // The scratchpad is clocked whenever the block is out of reset
    assign clken      = reset_n;

endmodule
